// File: rtl/skut_pkg.sv
// Shared SKUT frame-store types and constants.
// Status-pulse indices select bits of the registered status vector.
package skut_pkg;

  localparam int SKUT_DATA_W = 8;
  localparam int SKUT_ADDR_W = 7;
  localparam int SKUT_DEPTH  = 128;

  localparam logic [SKUT_DATA_W-1:0] SKUT_IDLE_WORD = 8'h80;

  localparam int STAT_SWAP_ACK = 0;
  localparam int STAT_UNDERRUN = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_W        = 3;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        inc
  );
    if (inc && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/skut_bank_ram.sv
// One bank of the SKUT ping-pong store.
// Simple dual-port RAM, synchronous read; q holds when re is low.
module skut_bank_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/skut_pingpong_buffer.sv
// Double-buffered SKUT frame store, write side -> DAC read side.
// Define SKUT_PINGPONG_STATS_EN for swap/underrun/overrun counters.
module skut_pingpong_buffer
  import skut_pkg::*;
#(
  parameter int DATA_W = SKUT_DATA_W,
  parameter int ADDR_W = SKUT_ADDR_W,
  parameter int DEPTH  = SKUT_DEPTH,
  parameter logic [DATA_W-1:0] IDLE_WORD = SKUT_IDLE_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic              swap_req,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank,
  output logic              swap_ack,
  output logic              underrun,
  output logic              overrun,
`ifdef SKUT_PINGPONG_STATS_EN
  output logic [15:0]       swap_cnt,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       overrun_cnt,
`endif
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic              rd_bank_q, rd_bank_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              addr_err_q, addr_err_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_idle_q, rd_idle_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic              wr_in, rd_in;
  logic              wr_ok, rd_ok;
  logic              swap;
  logic [1:0]        we, re;
  logic [DATA_W-1:0] bank_rdata [2];

  always_comb begin
    wr_in = {1'b0, wr_addr} < DEPTH_L;
    rd_in = {1'b0, rd_addr} < DEPTH_L;
    wr_ok = wr_en & wr_in;
    rd_ok = rd_en & rd_in & valid_q;
    // A frame finished this cycle may be swapped in immediately
    swap  = swap_req & (ready_q | wr_frame_done);

    we[0] = wr_ok & rd_bank_q;
    we[1] = wr_ok & ~rd_bank_q;
    re[0] = rd_ok & ~rd_bank_q;
    re[1] = rd_ok & rd_bank_q;

    rd_bank_d = rd_bank_q ^ swap;
    ready_d   = swap ? 1'b0 : (ready_q | wr_frame_done);
    valid_d   = valid_q | swap;

    stat_d = '0;
    stat_d[STAT_SWAP_ACK] = swap;
    stat_d[STAT_UNDERRUN] = swap_req & ~swap;
    stat_d[STAT_OVERRUN]  = wr_frame_done & ready_q & ~swap;

    addr_err_d = addr_err_q
               | (wr_en & ~wr_in)
               | (rd_en & ~rd_in);

    rd_sel_d  = rd_en ? rd_bank_q : rd_sel_q;
    rd_idle_d = rd_en ? ~(rd_in & valid_q) : rd_idle_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank_q  <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_idle_q  <= 1'b1;
      stat_q     <= '0;
    end else begin
      rd_bank_q  <= rd_bank_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
      rd_sel_q   <= rd_sel_d;
      rd_idle_q  <= rd_idle_d;
      stat_q     <= stat_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skut_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (re[b]),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  assign rd_data  = rd_idle_q ? IDLE_WORD : bank_rdata[rd_sel_q];
  assign rd_bank  = rd_bank_q;
  assign swap_ack = stat_q[STAT_SWAP_ACK];
  assign underrun = stat_q[STAT_UNDERRUN];
  assign overrun  = stat_q[STAT_OVERRUN];
  assign addr_err = addr_err_q;

`ifdef SKUT_PINGPONG_STATS_EN
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic [15:0] und_cnt_q, und_cnt_d;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    swap_cnt_d = sat_inc(swap_cnt_q, stat_d[STAT_SWAP_ACK]);
    und_cnt_d  = sat_inc(und_cnt_q, stat_d[STAT_UNDERRUN]);
    ovr_cnt_d  = sat_inc(ovr_cnt_q, stat_d[STAT_OVERRUN]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_cnt_q <= '0;
      und_cnt_q  <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      swap_cnt_q <= swap_cnt_d;
      und_cnt_q  <= und_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign swap_cnt     = swap_cnt_q;
  assign underrun_cnt = und_cnt_q;
  assign overrun_cnt  = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_skut_pingpong_buffer.sv
// Directed bench for skut_pingpong_buffer (default and DEPTH=100).
// Counter checks compile in with SKUT_PINGPONG_STATS_EN.
module tb_skut_pingpong_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_frame_done, swap_req, rd_en;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_bank, swap_ack, underrun, overrun, addr_err;

  logic       b_wr_en, b_wr_frame_done, b_swap_req, b_rd_en;
  logic [6:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data;
  logic [7:0] b_rd_data;
  logic       b_rd_bank, b_swap_ack, b_underrun, b_overrun, b_addr_err;

`ifdef SKUT_PINGPONG_STATS_EN
  logic [15:0] swap_cnt, underrun_cnt, overrun_cnt;
  logic [15:0] b_swap_cnt, b_underrun_cnt, b_overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skut_pingpong_buffer u_dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .swap_req      (swap_req),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_bank       (rd_bank),
    .swap_ack      (swap_ack),
    .underrun      (underrun),
    .overrun       (overrun),
`ifdef SKUT_PINGPONG_STATS_EN
    .swap_cnt      (swap_cnt),
    .underrun_cnt  (underrun_cnt),
    .overrun_cnt   (overrun_cnt),
`endif
    .addr_err      (addr_err)
  );

  skut_pingpong_buffer #(.DEPTH(100)) u_d100 (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (b_wr_en),
    .wr_addr       (b_wr_addr),
    .wr_data       (b_wr_data),
    .wr_frame_done (b_wr_frame_done),
    .swap_req      (b_swap_req),
    .rd_en         (b_rd_en),
    .rd_addr       (b_rd_addr),
    .rd_data       (b_rd_data),
    .rd_bank       (b_rd_bank),
    .swap_ack      (b_swap_ack),
    .underrun      (b_underrun),
    .overrun       (b_overrun),
`ifdef SKUT_PINGPONG_STATS_EN
    .swap_cnt      (b_swap_cnt),
    .underrun_cnt  (b_underrun_cnt),
    .overrun_cnt   (b_overrun_cnt),
`endif
    .addr_err      (b_addr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v, input bit use_addr);
    for (int i = 0; i < 128; i++) begin
      wr_en   = 1'b1;
      wr_addr = 7'(i);
      wr_data = use_addr ? 8'(i) : v;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic b_rd(input logic [6:0] a);
    b_rd_en   = 1'b1;
    b_rd_addr = a;
    tick();
    b_rd_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 0; wr_frame_done = 0; swap_req = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0;
    b_wr_en = 0; b_wr_frame_done = 0; b_swap_req = 0; b_rd_en = 0;
    b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
    tick(); tick();
    check("rst_rd_data", rd_data, 8'h80);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    check("rst_addr_err", addr_err, 0);
`ifdef SKUT_PINGPONG_STATS_EN
    check("rst_swap_cnt", swap_cnt, 0);
`endif
    rst = 1'b1;
    tick();

    for (int i = 0; i < 128; i++) begin
      rd(7'(i));
      check($sformatf("idle_rd_%0d", i), rd_data, 8'h80);
    end
    check("idle_rd_bank", rd_bank, 0);

    fill(8'h00, 1'b1);
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    check("fd1_overrun", overrun, 0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("sw1_ack", swap_ack, 1);
    check("sw1_rd_bank", rd_bank, 1);
    tick();
    check("sw1_ack_width", swap_ack, 0);
    rd(7'd5);
    check("sw1_rd5", rd_data, 8'h05);
    rd(7'd127);
    check("sw1_rd127", rd_data, 8'h7F);
    tick();
    check("rd_hold", rd_data, 8'h7F);

    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("ur1_underrun", underrun, 1);
    check("ur1_ack", swap_ack, 0);
    check("ur1_rd_bank", rd_bank, 1);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("ur2_underrun", underrun, 1);
    tick();
    check("ur2_width", underrun, 0);
    rd(7'd5);
    check("ur_rd5", rd_data, 8'h05);

    fill(8'hAA, 1'b0);
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    check("ov_first", overrun, 0);
    fill(8'h55, 1'b0);
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    check("ov_second", overrun, 1);
    tick();
    check("ov_width", overrun, 0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("ov_swap_ack", swap_ack, 1);
    check("ov_rd_bank", rd_bank, 0);
    rd(7'd10);
    check("ov_rd10", rd_data, 8'h55);

    wr_frame_done = 1'b1; swap_req = 1'b1;
    wr_en = 1'b1; wr_addr = 7'd3; wr_data = 8'hC3;
    rd_en = 1'b1; rd_addr = 7'd3;
    tick();
    wr_frame_done = 1'b0; swap_req = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    check("sim_rd_pre", rd_data, 8'h55);
    check("sim_ack", swap_ack, 1);
    check("sim_underrun", underrun, 0);
    check("sim_overrun", overrun, 0);
    check("sim_rd_bank", rd_bank, 1);
    rd(7'd3);
    check("sim_wr_landed", rd_data, 8'hC3);
    rd(7'd4);
    check("sim_bank1_rd4", rd_data, 8'h04);
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("sim_back_bank", rd_bank, 0);
    rd(7'd3);
    check("sim_bank0_clean", rd_data, 8'h55);
    check("main_addr_err", addr_err, 0);
`ifdef SKUT_PINGPONG_STATS_EN
    check("cnt_swap", swap_cnt, 16'd4);
    check("cnt_underrun", underrun_cnt, 16'd2);
    check("cnt_overrun", overrun_cnt, 16'd1);
`endif

    b_wr_en = 1'b1; b_wr_addr = 7'd56; b_wr_data = 8'h38; tick();
    b_wr_addr = 7'd99; b_wr_data = 8'h63; tick();
    check("d100_no_err", b_addr_err, 0);
    b_wr_addr = 7'd120; b_wr_data = 8'hEE; tick();
    b_wr_en = 1'b0;
    check("d100_wr_err", b_addr_err, 1);
    b_wr_frame_done = 1'b1; b_swap_req = 1'b1; tick();
    b_wr_frame_done = 1'b0; b_swap_req = 1'b0;
    check("d100_ack", b_swap_ack, 1);
    b_rd(7'd56);
    check("d100_rd56", b_rd_data, 8'h38);
    b_rd(7'd99);
    check("d100_rd99", b_rd_data, 8'h63);
    b_rd(7'd120);
    check("d100_rd120", b_rd_data, 8'h80);
    tick(); tick();
    check("d100_err_sticky", b_addr_err, 1);

    rst = 1'b0;
    #1;
    check("rst2_addr_err", b_addr_err, 0);
    check("rst2_rd_data", b_rd_data, 8'h80);
    check("rst2_main_bank", rd_bank, 0);
    check("rst2_main_data", rd_data, 8'h80);
    tick();
    rst = 1'b1;
    tick();
    rd(7'd3);
    check("rst2_invalid_rd", rd_data, 8'h80);

`ifdef SKUT_PINGPONG_STATS_EN
    check("rst2_swap_cnt", swap_cnt, 0);
    wr_frame_done = 1'b1; swap_req = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    wr_frame_done = 1'b0; swap_req = 1'b0;
    tick();
    check("sat_swap_cnt", swap_cnt, 16'hFFFF);
    check("sat_underrun_cnt", underrun_cnt, 0);
    check("sat_overrun_cnt", overrun_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
